// File: rtl/stepctl_pkg.sv
// Shared encodings for the stepper command path: command opcodes and the
// front-end state machine states. The command decoder imports the same package.
package stepctl_pkg;

   typedef enum logic [1:0] {
      OP_MOVE      = 2'd0,
      OP_SET_CLOCK = 2'd1,
      OP_FLUSH     = 2'd2,
      OP_CLEAR     = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_FLUSH1 = 3'd2,
      ST_FLUSH2 = 3'd3,
      ST_SHUT   = 3'd4
   } state_e;

endpackage

// File: rtl/stepdir_ctrl_if.sv
// Command port between the command decoder (master) and stepdir_ctrl (slave).
interface stepdir_ctrl_if #(
   parameter int MOVE_WIDTH = 100,
   parameter int CHAN_BITS  = 3
) ();

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [CHAN_BITS-1:0]  cmd_chan;
   logic [MOVE_WIDTH-1:0] cmd_data;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_chan,
      output cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_chan,
      input  cmd_data,
      output cmd_ready
   );

endinterface

// File: rtl/stepdir_ctrl.sv
// Command front end for a bank of stepdir channels: routes move / clock-set /
// flush commands onto the shared queue write bus and latches missed-clock
// errors into a global shutdown that holds every channel flushed until
// software acknowledges it.
module stepdir_ctrl
   import stepctl_pkg::*;
#(
   parameter int NUM_STEPPERS = 6,
   parameter int MOVE_WIDTH   = 100,
   parameter int CHAN_BITS    = $clog2(NUM_STEPPERS + 1)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   stepdir_ctrl_if.slave           cmd,
   output logic [MOVE_WIDTH-1:0]   q_wr_data,
   output logic [NUM_STEPPERS-1:0] q_wr_en,
   input  logic [NUM_STEPPERS-1:0] q_full,
   output logic [NUM_STEPPERS-1:0] rclk_en,
   output logic [31:0]             rclk_value,
   output logic [NUM_STEPPERS-1:0] st_reset,
   input  logic [NUM_STEPPERS-1:0] missed_clock,
   output logic                    shutdown,
   output logic [NUM_STEPPERS-1:0] shutdown_cause,
   output logic                    cmd_err
);

   localparam logic [NUM_STEPPERS-1:0] ALL_ONES = {NUM_STEPPERS{1'b1}};

   state_e                  state_reg, state_next;
   logic [MOVE_WIDTH-1:0]   q_wr_data_reg, q_wr_data_next;
   logic [NUM_STEPPERS-1:0] q_wr_en_reg, q_wr_en_next;
   logic [NUM_STEPPERS-1:0] rclk_en_reg, rclk_en_next;
   logic [31:0]             rclk_value_reg, rclk_value_next;
   logic [NUM_STEPPERS-1:0] st_reset_reg, st_reset_next;
   logic                    shutdown_reg, shutdown_next;
   logic [NUM_STEPPERS-1:0] cause_reg, cause_next;
   logic                    cmd_err_reg, cmd_err_next;
   logic [NUM_STEPPERS-1:0] ack_mask_reg, ack_mask_next;

   cmd_op_e                 op;
   logic [NUM_STEPPERS-1:0] err_bits;
   logic                    err_pending;
   logic                    chan_all;
   logic                    chan_bad;
   logic [NUM_STEPPERS-1:0] chan_hit;
   logic [NUM_STEPPERS-1:0] target_mask;
   logic                    sel_full;
   logic                    ready;
   logic                    accept;

   assign op          = cmd_op_e'(cmd.cmd_op);
   // Acknowledged channels are masked because stepdir never clears missed_clock.
   assign err_bits    = missed_clock & ~ack_mask_reg;
   assign err_pending = |err_bits;
   assign chan_all    = (cmd.cmd_chan == CHAN_BITS'(NUM_STEPPERS));
   assign chan_bad    = (cmd.cmd_chan >  CHAN_BITS'(NUM_STEPPERS));

   // One-hot channel decode; the all-channels code sets every target bit.
   for (genvar gi = 0; gi < NUM_STEPPERS; gi++) begin : g_chan
      assign chan_hit[gi]    = (cmd.cmd_chan == CHAN_BITS'(gi));
      assign target_mask[gi] = chan_hit[gi] | chan_all;
   end

   // Full flag of the addressed channel; zero for broadcast or invalid codes.
   assign sel_full = |(q_full & chan_hit);

   // Ready: IDLE takes anything except a MOVE into a full queue, and nothing
   // while an unacknowledged error waits; SHUT swallows every command.
   always_comb begin
      ready = 1'b0;
      case (state_reg)
         ST_IDLE: ready = !err_pending && !((op == OP_MOVE) && sel_full);
         ST_SHUT: ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   assign cmd.cmd_ready = ready;
   assign accept        = cmd.cmd_valid & ready;

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         q_wr_data_reg  <= '0;
         q_wr_en_reg    <= '0;
         rclk_en_reg    <= '0;
         rclk_value_reg <= '0;
         st_reset_reg   <= '0;
         shutdown_reg   <= 1'b0;
         cause_reg      <= '0;
         cmd_err_reg    <= 1'b0;
         ack_mask_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         q_wr_data_reg  <= q_wr_data_next;
         q_wr_en_reg    <= q_wr_en_next;
         rclk_en_reg    <= rclk_en_next;
         rclk_value_reg <= rclk_value_next;
         st_reset_reg   <= st_reset_next;
         shutdown_reg   <= shutdown_next;
         cause_reg      <= cause_next;
         cmd_err_reg    <= cmd_err_next;
         ack_mask_reg   <= ack_mask_next;
      end
   end

   // Next-state logic; shutdown entry beats any command in the same cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (err_pending) begin
               state_next = ST_FLUSH1;
            end else if (accept && !chan_bad) begin
               case (op)
                  OP_MOVE:      state_next = chan_all ? ST_IDLE : ST_ISSUE;
                  OP_SET_CLOCK: state_next = ST_ISSUE;
                  OP_FLUSH:     state_next = ST_FLUSH1;
                  default:      state_next = ST_IDLE;
               endcase
            end
         end
         ST_ISSUE:  state_next = ST_IDLE;
         ST_FLUSH1: state_next = ST_FLUSH2;
         // The shutdown flag decides whether this flush was a shutdown entry.
         ST_FLUSH2: state_next = shutdown_reg ? ST_SHUT : ST_IDLE;
         ST_SHUT: begin
            if (accept && (op == OP_CLEAR)) state_next = ST_IDLE;
         end
         default:   state_next = ST_IDLE;
      endcase
   end

   // Output next-values: strobes default low, data and status registers hold.
   always_comb begin
      q_wr_data_next  = q_wr_data_reg;
      q_wr_en_next    = '0;
      rclk_en_next    = '0;
      rclk_value_next = rclk_value_reg;
      st_reset_next   = '0;
      shutdown_next   = shutdown_reg;
      cause_next      = cause_reg;
      cmd_err_next    = 1'b0;
      ack_mask_next   = ack_mask_reg;
      case (state_reg)
         ST_IDLE: begin
            if (err_pending) begin
               shutdown_next = 1'b1;
               cause_next    = err_bits;
               st_reset_next = ALL_ONES;
            end else if (accept) begin
               if (chan_bad) begin
                  cmd_err_next = 1'b1;
               end else begin
                  case (op)
                     OP_MOVE: begin
                        if (chan_all) begin
                           cmd_err_next = 1'b1;
                        end else begin
                           q_wr_data_next = cmd.cmd_data;
                           q_wr_en_next   = target_mask;
                        end
                     end
                     OP_SET_CLOCK: begin
                        rclk_value_next = cmd.cmd_data[31:0];
                        rclk_en_next    = target_mask;
                     end
                     OP_FLUSH: st_reset_next = target_mask;
                     default:  ;
                  endcase
               end
            end
         end
         // stepdir samples queue_empty a cycle late, so reset spans two cycles.
         ST_FLUSH1: st_reset_next = st_reset_reg;
         ST_SHUT: begin
            if (accept && (op == OP_CLEAR)) begin
               ack_mask_next = ack_mask_reg | missed_clock;
               shutdown_next = 1'b0;
               cause_next    = '0;
            end
         end
         default: ;
      endcase
   end

   assign q_wr_data      = q_wr_data_reg;
   assign q_wr_en        = q_wr_en_reg;
   assign rclk_en        = rclk_en_reg;
   assign rclk_value     = rclk_value_reg;
   assign st_reset       = st_reset_reg;
   assign shutdown       = shutdown_reg;
   assign shutdown_cause = cause_reg;
   assign cmd_err        = cmd_err_reg;

endmodule

// File: tb/tb_stepdir_ctrl.sv
// Self-checking bench for stepdir_ctrl: a vector table for single commands,
// a strobe scoreboard, and hand-written sequences for flow control,
// shutdown entry/exit and reset during a flush.
module tb_stepdir_ctrl;

   localparam int N  = 6;
   localparam int MW = 100;
   localparam int CB = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [MW-1:0] q_wr_data;
   logic [N-1:0]  q_wr_en;
   logic [N-1:0]  q_full;
   logic [N-1:0]  rclk_en;
   logic [31:0]   rclk_value;
   logic [N-1:0]  st_reset;
   logic [N-1:0]  missed_clock;
   logic          shutdown;
   logic [N-1:0]  shutdown_cause;
   logic          cmd_err;

   stepdir_ctrl_if #(.MOVE_WIDTH(MW), .CHAN_BITS(CB)) cmd_bus ();

   stepdir_ctrl #(.NUM_STEPPERS(N), .MOVE_WIDTH(MW), .CHAN_BITS(CB)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cmd            (cmd_bus.slave),
      .q_wr_data      (q_wr_data),
      .q_wr_en        (q_wr_en),
      .q_full         (q_full),
      .rclk_en        (rclk_en),
      .rclk_value     (rclk_value),
      .st_reset       (st_reset),
      .missed_clock   (missed_clock),
      .shutdown       (shutdown),
      .shutdown_cause (shutdown_cause),
      .cmd_err        (cmd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    op;
      logic [CB-1:0] chan;
      logic [MW-1:0] data;
      logic [N-1:0]  exp_wr;
      logic [N-1:0]  exp_rclk;
      logic [N-1:0]  exp_st;
      logic          exp_err;
   } vec_t;

   typedef struct {
      int            due;
      logic [N-1:0]  wr_en;
      logic [MW-1:0] wr_data;
      logic [N-1:0]  rclk_en;
      logic [31:0]   rclk_value;
   } sb_t;

   localparam int NV = 12;
   vec_t vecs [NV];
   sb_t  sb_q [$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("[TB] ok %s = %0h", name, act);
      end
   endtask

   // Advance to the next falling edge and reconcile observed strobes with the scoreboard.
   task automatic tick();
      sb_t e;
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         e = sb_q.pop_front();
         check("sb_q_wr_en", 128'(q_wr_en), 128'(e.wr_en));
         if (e.wr_en != 0) check("sb_q_wr_data", 128'(q_wr_data), 128'(e.wr_data));
         check("sb_rclk_en", 128'(rclk_en), 128'(e.rclk_en));
         if (e.rclk_en != 0) check("sb_rclk_value", 128'(rclk_value), 128'(e.rclk_value));
      end else if (q_wr_en != 0 || rclk_en != 0) begin
         check("unexpected_strobe", 128'({q_wr_en, rclk_en}), 128'(0));
      end
   endtask

   // Present a command until accepted (bounded), predicting its strobes.
   task automatic send(input logic [1:0] op, input logic [CB-1:0] chan, input logic [MW-1:0] data,
                       input logic [N-1:0] exp_wr, input logic [N-1:0] exp_rclk, output int waits);
      sb_t e;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_chan  = chan;
      cmd_bus.cmd_data  = data;
      waits = 0;
      #1;
      while (!cmd_bus.cmd_ready && waits < 20) begin
         tick();
         #1;
         waits++;
      end
      if (!cmd_bus.cmd_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: op %0d chan %0d not accepted, ready %0b, required 1", op, chan, cmd_bus.cmd_ready);
         cmd_bus.cmd_valid = 1'b0;
         return;
      end
      if (exp_wr != 0 || exp_rclk != 0) begin
         e.due        = cyc + 1;
         e.wr_en      = exp_wr;
         e.wr_data    = data;
         e.rclk_en    = exp_rclk;
         e.rclk_value = data[31:0];
         sb_q.push_back(e);
      end
      tick();
      cmd_bus.cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int w, w2;

      vecs[0]  = '{2'd0, 3'd2, 100'h1234,                      6'b000100, 6'b000000, 6'b000000, 1'b0};
      vecs[1]  = '{2'd0, 3'd0, 100'hABCDEF0123456789ABCDEF012, 6'b000001, 6'b000000, 6'b000000, 1'b0};
      vecs[2]  = '{2'd0, 3'd5, 100'h7,                         6'b100000, 6'b000000, 6'b000000, 1'b0};
      vecs[3]  = '{2'd1, 3'd3, 100'h1234_5678,                 6'b000000, 6'b001000, 6'b000000, 1'b0};
      vecs[4]  = '{2'd1, 3'd6, 100'hFFFF_FFF0,                 6'b000000, 6'b111111, 6'b000000, 1'b0};
      vecs[5]  = '{2'd0, 3'd6, 100'h99,                        6'b000000, 6'b000000, 6'b000000, 1'b1};
      vecs[6]  = '{2'd2, 3'd1, 100'h0,                         6'b000000, 6'b000000, 6'b000010, 1'b0};
      vecs[7]  = '{2'd2, 3'd6, 100'h0,                         6'b000000, 6'b000000, 6'b111111, 1'b0};
      vecs[8]  = '{2'd2, 3'd7, 100'h0,                         6'b000000, 6'b000000, 6'b000000, 1'b1};
      vecs[9]  = '{2'd3, 3'd0, 100'h0,                         6'b000000, 6'b000000, 6'b000000, 1'b0};
      vecs[10] = '{2'd0, 3'd7, 100'h55,                        6'b000000, 6'b000000, 6'b000000, 1'b1};
      vecs[11] = '{2'd1, 3'd0, {68'hF_FFFF_FFFF_FFFF_FFFF, 32'h1}, 6'b000000, 6'b000001, 6'b000000, 1'b0};

      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_op    = 2'd0;
      cmd_bus.cmd_chan  = '0;
      cmd_bus.cmd_data  = '0;
      q_full            = '0;
      missed_clock      = '0;
      #1 reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Reset state
      check("rst_q_wr_en", 128'(q_wr_en), 128'(0));
      check("rst_rclk_en", 128'(rclk_en), 128'(0));
      check("rst_st_reset", 128'(st_reset), 128'(0));
      check("rst_shutdown", 128'(shutdown), 128'(0));
      check("rst_cause", 128'(shutdown_cause), 128'(0));
      check("rst_cmd_err", 128'(cmd_err), 128'(0));
      check("rst_q_wr_data", 128'(q_wr_data), 128'(0));
      check("rst_rclk_value", 128'(rclk_value), 128'(0));
      check("rst_cmd_ready", 128'(cmd_bus.cmd_ready), 128'(1));

      // Single-command vectors
      for (int i = 0; i < NV; i++) begin
         send(vecs[i].op, vecs[i].chan, vecs[i].data, vecs[i].exp_wr, vecs[i].exp_rclk, w);
         check($sformatf("v%0d_cmd_err", i), 128'(cmd_err), 128'(vecs[i].exp_err));
         check($sformatf("v%0d_st_reset1", i), 128'(st_reset), 128'(vecs[i].exp_st));
         tick();
         check($sformatf("v%0d_cmd_err_off", i), 128'(cmd_err), 128'(0));
         check($sformatf("v%0d_st_reset2", i), 128'(st_reset), 128'(vecs[i].exp_st));
         tick();
         check($sformatf("v%0d_st_reset3", i), 128'(st_reset), 128'(0));
      end

      // Back-to-back moves: second one waits out the ISSUE cycle
      send(2'd0, 3'd1, 100'h111, 6'b000010, 6'b0, w);
      send(2'd0, 3'd4, 100'h222, 6'b010000, 6'b0, w2);
      check("b2b_first_wait", 128'(w), 128'(0));
      check("b2b_second_wait", 128'(w2), 128'(1));
      tick();

      // Full queue holds off a move; strobe follows once full drops
      q_full            = 6'b000001;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = 2'd0;
      cmd_bus.cmd_chan  = 3'd0;
      cmd_bus.cmd_data  = 100'h3C3C;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("full_ready_c%0d", i), 128'(cmd_bus.cmd_ready), 128'(0));
         tick();
      end
      q_full = '0;
      send(2'd0, 3'd0, 100'h3C3C, 6'b000001, 6'b0, w);
      check("full_release_wait", 128'(w), 128'(0));
      tick();

      // Missed clock arriving with a move: shutdown wins, move not taken
      missed_clock      = 6'b010000;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = 2'd0;
      cmd_bus.cmd_chan  = 3'd3;
      cmd_bus.cmd_data  = 100'hBAD;
      #1;
      check("shut_entry_ready", 128'(cmd_bus.cmd_ready), 128'(0));
      tick();
      cmd_bus.cmd_valid = 1'b0;
      check("shut_flag", 128'(shutdown), 128'(1));
      check("shut_cause", 128'(shutdown_cause), 128'(6'b010000));
      check("shut_st_reset1", 128'(st_reset), 128'(6'b111111));
      tick();
      check("shut_st_reset2", 128'(st_reset), 128'(6'b111111));
      tick();
      check("shut_st_reset3", 128'(st_reset), 128'(0));
      #1;
      check("shut_ready", 128'(cmd_bus.cmd_ready), 128'(1));

      // Commands in SHUT are swallowed
      send(2'd0, 3'd2, 100'h1, 6'b0, 6'b0, w);
      send(2'd1, 3'd6, 100'h2, 6'b0, 6'b0, w);
      send(2'd2, 3'd1, 100'h0, 6'b0, 6'b0, w);
      tick();
      check("shut_flush_dropped", 128'(st_reset), 128'(0));
      check("shut_still", 128'(shutdown), 128'(1));

      // Acknowledge while missed_clock[4] stays high
      send(2'd3, 3'd0, 100'h0, 6'b0, 6'b0, w);
      check("clear_shutdown", 128'(shutdown), 128'(0));
      check("clear_cause", 128'(shutdown_cause), 128'(0));
      repeat (3) tick();
      check("clear_no_reentry", 128'(shutdown), 128'(0));
      send(2'd0, 3'd1, 100'h55, 6'b000010, 6'b0, w);
      check("clear_move_wait", 128'(w), 128'(0));

      // New error raised during ISSUE is acted on at the next IDLE cycle
      missed_clock = 6'b010010;
      tick();
      check("reentry_deferred", 128'(shutdown), 128'(0));
      tick();
      check("reentry_flag", 128'(shutdown), 128'(1));
      check("reentry_cause", 128'(shutdown_cause), 128'(6'b000010));
      repeat (2) tick();
      send(2'd3, 3'd0, 100'h0, 6'b0, 6'b0, w);
      check("reclear_shutdown", 128'(shutdown), 128'(0));
      tick();

      // Asynchronous reset in FLUSH1 drops st_reset at once
      send(2'd2, 3'd5, 100'h0, 6'b0, 6'b0, w);
      check("rflush_st_reset", 128'(st_reset), 128'(6'b100000));
      #1 reset_n = 1'b0;
      #1;
      check("rflush_st_reset_cleared", 128'(st_reset), 128'(0));
      missed_clock = '0;
      tick();
      reset_n = 1'b1;
      tick();
      check("post_reset_st_reset", 128'(st_reset), 128'(0));
      check("post_reset_shutdown", 128'(shutdown), 128'(0));
      send(2'd0, 3'd3, 100'hFEED, 6'b001000, 6'b0, w);
      repeat (2) tick();
      check("sb_drained", 128'(sb_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
